// File: rtl/oam_dma.sv
// oam_dma: copies one 256-byte CPU page into sprite OAM after a write to $4014, halting the CPU meanwhile.
// Latency: cpu_rdy drops the cycle after reg_wr and stays low 513 cycles (514 if the write landed on an odd cycle).
// Backpressure: none; the CPU is stalled via cpu_rdy and any reg_wr arriving while busy is ignored.
//
// Ports:
//   clk, reset                  - system clock, async active-high reset
//   reg_wr, cpu_data_in         - $4014 write strobe and source page number
//   cpu_odd_cycle, oam_addr_base - CPU cycle parity and OAMADDR, sampled with reg_wr
//   mem_addr, mem_rd, mem_data_in - CPU-bus read port (data returns the cycle after mem_rd)
//   oam_addr_out, oam_data_out, oam_WE - OAM write port, one-cycle pulse per byte
//   cpu_rdy, busy               - CPU halt (active low) and transfer-in-progress flags
module oam_dma (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_wr,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_odd_cycle,
    input  logic [7:0]  oam_addr_base,
    input  logic [7:0]  mem_data_in,
    output logic        cpu_rdy,
    output logic        busy,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic [7:0]  oam_addr_out,
    output logic [7:0]  oam_data_out,
    output logic        oam_WE
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t     state;
    logic [7:0] page;
    logic [7:0] base;
    logic [7:0] index;
    logic       odd;
    logic [7:0] index_nxt;

    assign index_nxt = index + 8'd1;

    // mem_rd and mem_addr are loaded on the edge that enters READ so that
    // they are registered and valid for exactly the READ cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            page         <= 8'd0;
            base         <= 8'd0;
            index        <= 8'd0;
            odd          <= 1'b0;
            cpu_rdy      <= 1'b1;
            busy         <= 1'b0;
            mem_addr     <= 16'd0;
            mem_rd       <= 1'b0;
            oam_addr_out <= 8'd0;
            oam_data_out <= 8'd0;
            oam_WE       <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            oam_WE <= 1'b0;
            case (state)
                IDLE: begin
                    if (reg_wr) begin
                        page    <= cpu_data_in;
                        base    <= oam_addr_base;
                        odd     <= cpu_odd_cycle;
                        index   <= 8'd0;
                        cpu_rdy <= 1'b0;
                        busy    <= 1'b1;
                        state   <= HALT;
                    end
                end
                HALT: begin
                    if (odd) begin
                        state <= ALIGN;
                    end else begin
                        state    <= READ;
                        mem_rd   <= 1'b1;
                        mem_addr <= {page, index};
                    end
                end
                ALIGN: begin
                    state    <= READ;
                    mem_rd   <= 1'b1;
                    mem_addr <= {page, index};
                end
                READ: begin
                    state <= WRITE;
                end
                WRITE: begin
                    // mem_data_in carries the byte requested in the previous READ cycle.
                    oam_data_out <= mem_data_in;
                    oam_addr_out <= base + index;
                    oam_WE       <= 1'b1;
                    index        <= index_nxt;
                    if (index == 8'hFF) begin
                        state   <= IDLE;
                        cpu_rdy <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        state    <= READ;
                        mem_rd   <= 1'b1;
                        mem_addr <= {page, index_nxt};
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: randomized bench for oam_dma against a per-transfer list model.
// Latency: n/a (testbench).
// Backpressure: n/a; a behavioural memory answers each mem_rd on the following cycle.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_wr;
    logic [7:0]  cpu_data_in;
    logic        cpu_odd_cycle;
    logic [7:0]  oam_addr_base;
    logic [7:0]  mem_data_in;
    logic        cpu_rdy;
    logic        busy;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  oam_addr_out;
    logic [7:0]  oam_data_out;
    logic        oam_WE;

    oam_dma dut (
        .clk           (clk),
        .reset         (reset),
        .reg_wr        (reg_wr),
        .cpu_data_in   (cpu_data_in),
        .cpu_odd_cycle (cpu_odd_cycle),
        .oam_addr_base (oam_addr_base),
        .mem_data_in   (mem_data_in),
        .cpu_rdy       (cpu_rdy),
        .busy          (busy),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .oam_addr_out  (oam_addr_out),
        .oam_data_out  (oam_data_out),
        .oam_WE        (oam_WE)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:65535];

    // Memory answers the request seen in the READ cycle; data is stable through WRITE.
    always @(negedge clk) begin
        if (mem_rd) mem_data_in = mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observations of the most recent transfer.
    logic [7:0] wr_a[$];
    logic [7:0] wr_d[$];
    int         low_cnt, rd_cnt, first_rd, bad_range, dbl_rd;
    bit         done, aborted;

    task automatic fill_page(input logic [7:0] pg, input int mode);
        for (int i = 0; i < 256; i++) begin
            case (mode)
                0:       mem[{pg, 8'(i)}] = 8'(i);
                1:       mem[{pg, 8'(i)}] = ~8'(i);
                default: mem[{pg, 8'(i)}] = 8'($urandom);
            endcase
        end
    endtask

    // Starts a transfer and observes it cycle by cycle. wr_at injects a reg_wr
    // (page 0x07) in that transfer cycle; rst_after asserts reset once that
    // many OAM writes have been seen.
    task automatic xfer(input logic [7:0] pg, input logic [7:0] bs, input logic od,
                        input int wr_at, input int rst_after);
        bit prev_rd;
        wr_a.delete();
        wr_d.delete();
        low_cnt = 0; rd_cnt = 0; first_rd = -1; bad_range = 0; dbl_rd = 0;
        done = 0; aborted = 0; prev_rd = 0;
        @(negedge clk);
        reg_wr = 1'b1; cpu_data_in = pg; oam_addr_base = bs; cpu_odd_cycle = od;
        @(negedge clk);
        reg_wr = 1'b0; cpu_data_in = 8'($urandom); oam_addr_base = 8'($urandom);
        cpu_odd_cycle = 1'($urandom);
        for (int cyc = 1; cyc <= 1000; cyc++) begin
            if (!cpu_rdy) low_cnt++;
            if (mem_rd) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
                if (mem_addr[15:8] !== pg) bad_range++;
                if (prev_rd) dbl_rd++;
            end
            prev_rd = mem_rd;
            if (oam_WE) begin
                wr_a.push_back(oam_addr_out);
                wr_d.push_back(oam_data_out);
            end
            if (cyc == wr_at + 1) reg_wr = 1'b0;
            if (cyc == wr_at) begin
                reg_wr = 1'b1; cpu_data_in = 8'h07;
                oam_addr_base = 8'($urandom); cpu_odd_cycle = ~od;
            end
            if (rst_after > 0 && wr_a.size() == rst_after) begin
                reset = 1'b1;
                aborted = 1;
                break;
            end
            if (cpu_rdy === 1'b1 && busy === 1'b0) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        reg_wr = 1'b0;
        if (!done && !aborted) chk("timeout", 0, 1);
    endtask

    // Model: byte i of the page lands at OAM[(base+i) mod 256]; CPU halted
    // 513 cycles plus one alignment cycle when the write was on an odd cycle.
    task automatic check_xfer(input string tag, input logic [7:0] pg, input logic [7:0] bs,
                              input logic od);
        int n;
        chk({tag, "_rdy_low"}, low_cnt, 513 + int'(od));
        chk({tag, "_reads"}, rd_cnt, 256);
        chk({tag, "_writes"}, wr_a.size(), 256);
        chk({tag, "_first_rd"}, first_rd, 2 + int'(od));
        chk({tag, "_addr_range"}, bad_range, 0);
        chk({tag, "_dbl_rd"}, dbl_rd, 0);
        chk({tag, "_last_we"}, {oam_WE, cpu_rdy}, 2'b11);
        n = (wr_a.size() < 256) ? wr_a.size() : 256;
        for (int i = 0; i < n; i++)
            chk({tag, "_wr"}, {wr_a[i], wr_d[i]}, {8'(bs + 8'(i)), mem[{pg, 8'(i)}]});
        @(negedge clk);
        chk({tag, "_we_clear"}, oam_WE, 0);
        chk({tag, "_addr_hold"}, mem_addr, {pg, 8'hFF});
    endtask

    initial begin
        logic [7:0] pg, bs;
        logic       od;
        int         cnt;

        reset = 1'b1; reg_wr = 1'b0; cpu_data_in = 8'd0; cpu_odd_cycle = 1'b0;
        oam_addr_base = 8'd0; mem_data_in = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {cpu_rdy, busy, mem_rd, oam_WE}, 4'b1000);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_oam", {oam_addr_out, oam_data_out}, 16'h0000);
        reset = 1'b0;
        @(negedge clk);

        // Identity page, even cycle.
        fill_page(8'h02, 0);
        xfer(8'h02, 8'h00, 1'b0, -5, 0);
        check_xfer("even", 8'h02, 8'h00, 1'b0);

        // Same page, odd cycle: one extra alignment cycle.
        xfer(8'h02, 8'h00, 1'b1, -5, 0);
        check_xfer("odd", 8'h02, 8'h00, 1'b1);

        // Wrapping OAM address with inverted data.
        fill_page(8'h03, 1);
        xfer(8'h03, 8'hF0, 1'b0, -5, 0);
        check_xfer("wrap", 8'h03, 8'hF0, 1'b0);
        if (wr_a.size() == 256) begin
            chk("wrap_first", {wr_a[0], wr_d[0]}, 16'hF0FF);
            chk("wrap_zero", {wr_a[16], wr_d[16]}, 16'h00EF);
            chk("wrap_last", wr_a[255], 8'hEF);
        end

        // reg_wr during a transfer is ignored.
        fill_page(8'h07, 2);
        fill_page(8'h02, 2);
        xfer(8'h02, 8'h40, 1'b0, 100, 0);
        check_xfer("busy_wr", 8'h02, 8'h40, 1'b0);

        // reg_wr in the final WRITE cycle must not start a new transfer.
        xfer(8'h02, 8'h11, 1'b0, 513, 0);
        check_xfer("end_wr", 8'h02, 8'h11, 1'b0);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || !cpu_rdy || mem_rd) cnt++;
        end
        chk("end_wr_idle", cnt, 0);

        // Reset mid-transfer.
        fill_page(8'h05, 2);
        xfer(8'h05, 8'h20, 1'b1, -5, 40);
        chk("rst_hit", aborted, 1);
        @(negedge clk);
        chk("midrst_outs", {cpu_rdy, busy, oam_WE, mem_rd}, 4'b1000);
        chk("midrst_writes", wr_a.size(), 40);
        reset = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (oam_WE || mem_rd || busy) cnt++;
        end
        chk("midrst_quiet", cnt, 0);
        xfer(8'h05, 8'h20, 1'b1, -5, 0);
        check_xfer("after_rst", 8'h05, 8'h20, 1'b1);

        // Random transfers with random intrusive reg_wr.
        for (int k = 0; k < 4; k++) begin
            pg = 8'($urandom_range(8, 255));
            if (pg == 8'h07) pg = 8'h08;
            bs = 8'($urandom);
            od = 1'($urandom);
            fill_page(pg, 2);
            xfer(pg, bs, od, $urandom_range(3, 500), 0);
            check_xfer("rand", pg, bs, od);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
